// File: rtl/rq_arbiter.sv
// rq_arbiter: packet-atomic round-robin merge of RQ requesters, 2-entry skid out.
// Build option: define RQ_ARB_PRIO0_EN to give port 0 strict priority in IDLE.
module rq_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int NUM_PORTS  = 3,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             user_clk,
  input  logic                             user_reset_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_rq_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_rq_tkeep,
  input  logic [NUM_PORTS-1:0]             s_axis_rq_tlast,
  input  logic [NUM_PORTS*4-1:0]           s_axis_rq_tuser,
  input  logic [NUM_PORTS-1:0]             s_axis_rq_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_rq_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_rq_tkeep,
  output logic                             m_axis_rq_tlast,
  output logic [3:0]                       m_axis_rq_tuser,
  output logic                             m_axis_rq_tvalid,
  input  logic                             m_axis_rq_tready,
  output logic [PW-1:0]                    grant_owner,
  output logic                             grant_locked
);

  localparam int WW = DATA_WIDTH + KEEP_WIDTH + 5;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   rr_sel;
  logic [PW-1:0]   granted;
  logic [PW-1:0]   nxt_ptr;
  logic            any_vld;
  logic            gnt_vld;
  logic            upd_ptr;
  logic            in_rdy;
  logic            acc;
  logic            beat_last;
  logic [WW-1:0]   beat;

  logic [WW-1:0]   e0_q;
  logic [WW-1:0]   e1_q;
  logic            e0_v;
  logic            e1_v;
  logic            e1_nxt;
  logic            drain;
  logic            to_e0;
  logic            to_e1;
  logic            shift;
  logic            pop;

  function automatic logic [PW-1:0] rr_idx(
    input logic [PW-1:0] base,
    input int            j
  );
    int k;
    k = int'(base) + j;
    if (k >= NUM_PORTS) k = k - NUM_PORTS;
    return PW'(k);
  endfunction

  // Descending scan so the nearest port at or above rr_ptr wins.
  always_comb begin
    rr_sel  = rr_ptr;
    any_vld = 1'b0;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (s_axis_rq_tvalid[rr_idx(rr_ptr, j)]) begin
        rr_sel  = rr_idx(rr_ptr, j);
        any_vld = 1'b1;
      end
    end
`ifdef RQ_ARB_PRIO0_EN
    if (s_axis_rq_tvalid[0]) rr_sel = '0;
`endif
  end

  assign granted = (state == LOCKED) ? owner : rr_sel;
  assign gnt_vld = (state == LOCKED) | any_vld;

  always_comb begin
    s_axis_rq_tready = '0;
    beat             = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (granted == PW'(i)) begin
        s_axis_rq_tready[i] = in_rdy & gnt_vld;
        beat = {s_axis_rq_tuser[i*4 +: 4],
                s_axis_rq_tlast[i],
                s_axis_rq_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH],
                s_axis_rq_tdata[i*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  assign acc       = |(s_axis_rq_tready & s_axis_rq_tvalid);
  assign beat_last = beat[DATA_WIDTH + KEEP_WIDTH];

  assign nxt_ptr = (granted == PW'(NUM_PORTS - 1)) ? '0
                 : granted + 1'b1;

`ifdef RQ_ARB_PRIO0_EN
  assign upd_ptr = (granted != '0);
`else
  assign upd_ptr = 1'b1;
`endif

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else if (acc) begin
      owner <= granted;
      if (beat_last) begin
        state <= IDLE;
        if (upd_ptr) rr_ptr <= nxt_ptr;
      end else begin
        state <= LOCKED;
      end
    end
  end

  assign grant_locked = (state == LOCKED);
  assign grant_owner  = owner;

  // Accept implies entry1 empty, since in_rdy mirrors it.
  assign drain  = e0_v & m_axis_rq_tready;
  assign to_e0  = acc & (~e0_v | drain);
  assign to_e1  = acc & e0_v & ~drain;
  assign shift  = ~acc & drain & e1_v;
  assign pop    = ~acc & drain & ~e1_v;
  assign e1_nxt = to_e1 | (e1_v & ~drain);

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      e0_q   <= '0;
      e1_q   <= '0;
      e0_v   <= 1'b0;
      e1_v   <= 1'b0;
      in_rdy <= 1'b0;
    end else begin
      unique case (1'b1)
        to_e0: begin
          e0_q <= beat;
          e0_v <= 1'b1;
        end
        to_e1: begin
          e1_q <= beat;
          e1_v <= 1'b1;
        end
        shift: begin
          e0_q <= e1_q;
          e1_v <= 1'b0;
        end
        pop: begin
          e0_v <= 1'b0;
        end
        default: begin
        end
      endcase
      in_rdy <= ~e1_nxt;
    end
  end

  assign {m_axis_rq_tuser,
          m_axis_rq_tlast,
          m_axis_rq_tkeep,
          m_axis_rq_tdata} = e0_q;
  assign m_axis_rq_tvalid = e0_v;

endmodule

// File: tb/tb_rq_arbiter.sv
// tb_rq_arbiter: scoreboard bench for rq_arbiter (3 ports, 128-bit beats).
// Expected output order is built per scenario; honours RQ_ARB_PRIO0_EN.
module tb_rq_arbiter;
  localparam int DW = 128;
  localparam int KW = 16;
  localparam int NP = 3;
  localparam int WW = DW + KW + 5;
  localparam int LG = 64;

  logic           user_clk = 1'b0;
  logic           user_reset_n = 1'b0;
  logic [NP*DW-1:0] s_axis_rq_tdata;
  logic [NP*KW-1:0] s_axis_rq_tkeep;
  logic [NP-1:0]  s_axis_rq_tlast;
  logic [NP*4-1:0] s_axis_rq_tuser;
  logic [NP-1:0]  s_axis_rq_tvalid;
  logic [NP-1:0]  s_axis_rq_tready;
  logic [DW-1:0]  m_axis_rq_tdata;
  logic [KW-1:0]  m_axis_rq_tkeep;
  logic           m_axis_rq_tlast;
  logic [3:0]     m_axis_rq_tuser;
  logic           m_axis_rq_tvalid;
  logic           m_axis_rq_tready;
  logic [1:0]     grant_owner;
  logic           grant_locked;

  always #5 user_clk = ~user_clk;

  rq_arbiter #(
    .DATA_WIDTH(DW),
    .KEEP_WIDTH(KW),
    .NUM_PORTS(NP)
  ) dut (
    .user_clk(user_clk),
    .user_reset_n(user_reset_n),
    .s_axis_rq_tdata(s_axis_rq_tdata),
    .s_axis_rq_tkeep(s_axis_rq_tkeep),
    .s_axis_rq_tlast(s_axis_rq_tlast),
    .s_axis_rq_tuser(s_axis_rq_tuser),
    .s_axis_rq_tvalid(s_axis_rq_tvalid),
    .s_axis_rq_tready(s_axis_rq_tready),
    .m_axis_rq_tdata(m_axis_rq_tdata),
    .m_axis_rq_tkeep(m_axis_rq_tkeep),
    .m_axis_rq_tlast(m_axis_rq_tlast),
    .m_axis_rq_tuser(m_axis_rq_tuser),
    .m_axis_rq_tvalid(m_axis_rq_tvalid),
    .m_axis_rq_tready(m_axis_rq_tready),
    .grant_owner(grant_owner),
    .grant_locked(grant_locked)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [3:0]    user;
    int            gap;
  } beat_t;

  beat_t pq[NP][$];
  beat_t sb[$];
  int checks = 0;
  int errors = 0;
  int stall_s = 0;
  int stall_n = 0;
  int first_acc, first_out, n_out, ncyc;
  logic [NP-1:0] acc_log[LG];
  logic [NP-1:0] rdy_log[LG];
  logic lock_log[LG];
  logic ov_log[LG];

  function automatic logic [WW-1:0] wrd(input beat_t b);
    return {b.user, b.last, b.keep, b.data};
  endfunction

  task automatic add(input int p, input int k, input int b,
                     input bit last, input int gap,
                     input bit to_sb, output beat_t t);
    t.data = {$urandom, $urandom, $urandom,
              8'(p), 8'(k), 8'(b), 8'hA5};
    t.keep = 16'($urandom);
    t.user = 4'($urandom);
    t.last = last;
    t.gap  = gap;
    pq[p].push_back(t);
    if (to_sb) sb.push_back(t);
  endtask

  task automatic present(input int i, input int gl);
    if (pq[i].size() == 0 || gl > 0) begin
      s_axis_rq_tvalid[i] = 1'b0;
      s_axis_rq_tlast[i]  = 1'b0;
    end else begin
      s_axis_rq_tdata[i*DW +: DW] = pq[i][0].data;
      s_axis_rq_tkeep[i*KW +: KW] = pq[i][0].keep;
      s_axis_rq_tuser[i*4 +: 4]   = pq[i][0].user;
      s_axis_rq_tlast[i]          = pq[i][0].last;
      s_axis_rq_tvalid[i]         = 1'b1;
    end
  endtask

  task automatic run();
    int gl[NP];
    int c, tail;
    logic [NP-1:0] acc;
    logic pv, pr;
    logic [WW-1:0] pw, ow;
    beat_t e;
    bit empty;
    c = 0; tail = 0; pv = 1'b0; pr = 1'b1; pw = '0;
    first_acc = -1; first_out = -1; n_out = 0;
    for (int i = 0; i < NP; i++) begin
      gl[i] = (pq[i].size() > 0) ? pq[i][0].gap : 0;
      present(i, gl[i]);
    end
    while (c < LG - 4 && tail < 3) begin
      m_axis_rq_tready = !(c >= stall_s && c < stall_s + stall_n);
      @(negedge user_clk);
      acc = s_axis_rq_tvalid & s_axis_rq_tready;
      acc_log[c] = acc;
      rdy_log[c] = s_axis_rq_tready;
      lock_log[c] = grant_locked;
      ov_log[c] = m_axis_rq_tvalid;
      if (acc != '0 && first_acc < 0) first_acc = c;
      if (m_axis_rq_tvalid && first_out < 0) first_out = c;
      ow = {m_axis_rq_tuser, m_axis_rq_tlast,
            m_axis_rq_tkeep, m_axis_rq_tdata};
      if (pv && !pr) begin
        checks++;
        if (m_axis_rq_tvalid !== 1'b1 || ow !== pw) begin
          errors++;
          $display("FAIL hold: valid=%b word=%h required valid=1 word=%h",
                   m_axis_rq_tvalid, ow, pw);
        end
      end
      if (m_axis_rq_tvalid && m_axis_rq_tready) begin
        n_out++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got %h required none", ow);
        end else begin
          e = sb.pop_front();
          if (ow !== wrd(e)) begin
            errors++;
            $display("FAIL out_beat: got %h required %h", ow, wrd(e));
          end
        end
      end
      pv = m_axis_rq_tvalid;
      pr = m_axis_rq_tready;
      pw = ow;
      @(posedge user_clk);
      #1;
      empty = (sb.size() == 0);
      for (int i = 0; i < NP; i++) begin
        if (acc[i]) begin
          void'(pq[i].pop_front());
          gl[i] = (pq[i].size() > 0) ? pq[i][0].gap : 0;
        end else if (gl[i] > 0) begin
          gl[i]--;
        end
        present(i, gl[i]);
        if (pq[i].size() != 0) empty = 1'b0;
      end
      tail = empty ? tail + 1 : 0;
      c++;
    end
    ncyc = c;
    if (tail < 3) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d beats left required 0", sb.size());
      sb.delete();
      for (int i = 0; i < NP; i++) pq[i].delete();
    end
  endtask

  task automatic idle_inputs();
    s_axis_rq_tdata  = '0;
    s_axis_rq_tkeep  = '0;
    s_axis_rq_tlast  = '0;
    s_axis_rq_tuser  = '0;
    s_axis_rq_tvalid = '0;
    m_axis_rq_tready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    user_reset_n = 1'b0;
    repeat (2) @(posedge user_clk);
    #1 user_reset_n = 1'b1;
    @(posedge user_clk);
    #1;
  endtask

  task automatic test_reset();
    beat_t t;
    idle_inputs();
    user_reset_n = 1'b0;
    repeat (2) @(posedge user_clk);
    #1;
    checks++;
    if (m_axis_rq_tvalid !== 1'b0 || grant_locked !== 1'b0 ||
        s_axis_rq_tready !== 3'b000 || grant_owner !== 2'd0) begin
      errors++;
      $display("FAIL rst_state: v=%b lk=%b rdy=%b own=%0d required 0 0 000 0",
               m_axis_rq_tvalid, grant_locked, s_axis_rq_tready, grant_owner);
    end
    user_reset_n = 1'b1;
    @(posedge user_clk);
    #1;
    s_axis_rq_tdata[DW +: DW] = 128'h1234;
    s_axis_rq_tvalid[1] = 1'b1;
    s_axis_rq_tlast[1]  = 1'b0;
    m_axis_rq_tready    = 1'b0;
    @(posedge user_clk);
    #1;
    s_axis_rq_tvalid = '0;
    checks++;
    if (grant_locked !== 1'b1 || m_axis_rq_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pkt: lk=%b v=%b required 1 1",
               grant_locked, m_axis_rq_tvalid);
    end
    #2 user_reset_n = 1'b0;
    #1;
    checks++;
    if (m_axis_rq_tvalid !== 1'b0 || grant_locked !== 1'b0 ||
        s_axis_rq_tready !== 3'b000) begin
      errors++;
      $display("FAIL async_rst: v=%b lk=%b rdy=%b required 0 0 000",
               m_axis_rq_tvalid, grant_locked, s_axis_rq_tready);
    end
    @(posedge user_clk);
    #1 user_reset_n = 1'b1;
    m_axis_rq_tready = 1'b1;
    @(posedge user_clk);
    #1;
    add(2, 0, 0, 1'b1, 0, 1'b1, t);
    run();
    checks++;
    if (first_acc < 0 || first_out != first_acc + 1) begin
      errors++;
      $display("FAIL latency: out cycle %0d required %0d",
               first_out, first_acc + 1);
    end
    add(0, 0, 0, 1'b1, 0, 1'b1, t);
    add(1, 0, 0, 1'b1, 0, 1'b1, t);
    run();
    checks++;
    if (grant_owner !== 2'd1) begin
      errors++;
      $display("FAIL owner_after_wrap: got %0d required 1", grant_owner);
    end
  endtask

  task automatic test_round_robin();
    beat_t bk[NP][2][2];
    int ord[6];
    int cnt[NP];
    int gaps;
    do_reset();
`ifdef RQ_ARB_PRIO0_EN
    ord = '{0, 0, 1, 2, 1, 2};
`else
    ord = '{0, 1, 2, 0, 1, 2};
`endif
    for (int p = 0; p < NP; p++) begin
      cnt[p] = 0;
      for (int k = 0; k < 2; k++)
        for (int b = 0; b < 2; b++)
          add(p, k, b, b == 1, 0, 1'b0, bk[p][k][b]);
    end
    for (int n = 0; n < 6; n++) begin
      sb.push_back(bk[ord[n]][cnt[ord[n]]][0]);
      sb.push_back(bk[ord[n]][cnt[ord[n]]][1]);
      cnt[ord[n]]++;
    end
    run();
    gaps = 0;
    for (int c = 0; c < 12; c++)
      if (first_out < 0 || ov_log[first_out + c] !== 1'b1) gaps++;
    checks++;
    if (gaps != 0 || n_out != 12) begin
      errors++;
      $display("FAIL rr_no_bubble: gaps=%0d beats=%0d required 0 12",
               gaps, n_out);
    end
    checks++;
    if (grant_owner !== 2'd2) begin
      errors++;
      $display("FAIL rr_owner: got %0d required 2", grant_owner);
    end
  endtask

  task automatic test_atomicity();
    beat_t t;
    int c1f, c1l, bad, n1;
    do_reset();
    add(1, 0, 0, 1'b0, 0, 1'b1, t);
    add(1, 0, 1, 1'b0, 3, 1'b1, t);
    add(1, 0, 2, 1'b1, 0, 1'b1, t);
    add(0, 0, 0, 1'b1, 1, 1'b1, t);
    run();
    c1f = -1; c1l = -1; n1 = 0;
    for (int c = 0; c < ncyc; c++)
      if (acc_log[c][1]) begin
        if (c1f < 0) c1f = c;
        c1l = c;
        n1++;
      end
    bad = 0;
    for (int c = c1f + 1; c <= c1l; c++)
      if (lock_log[c] !== 1'b1) bad++;
    checks++;
    if (bad != 0 || n1 != 3 || c1l - c1f < 5) begin
      errors++;
      $display("FAIL atomic_lock: unlocked=%0d beats=%0d span=%0d required 0 3 >=5",
               bad, n1, c1l - c1f);
    end
  endtask

  task automatic test_backpressure();
    beat_t t;
    int na, nr;
    do_reset();
    stall_s = 0;
    stall_n = 5;
    for (int b = 0; b < 4; b++)
      add(2, 0, b, b == 3, 0, 1'b1, t);
    run();
    stall_n = 0;
    na = 0;
    for (int c = 0; c < 5; c++)
      if (acc_log[c][2]) na++;
    checks++;
    if (na != 2) begin
      errors++;
      $display("FAIL bp_absorb: accepted %0d required 2", na);
    end
    nr = 0;
    for (int c = 2; c < 6; c++)
      if (rdy_log[c][2] !== 1'b0) nr++;
    checks++;
    if (nr != 0 || rdy_log[6][2] !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready: high_in_stall=%0d rdy6=%b required 0 1",
               nr, rdy_log[6][2]);
    end
    checks++;
    if (n_out != 4) begin
      errors++;
      $display("FAIL bp_count: got %0d required 4", n_out);
    end
  endtask

  task automatic test_priority();
    beat_t t, x, y, z, w;
    do_reset();
    add(0, 0, 0, 1'b1, 0, 1'b1, t);
    run();
    add(1, 1, 0, 1'b0, 0, 1'b0, x);
    add(1, 1, 1, 1'b1, 0, 1'b0, y);
    add(2, 1, 0, 1'b1, 0, 1'b0, z);
    add(0, 1, 0, 1'b1, 1, 1'b0, w);
    sb.push_back(x);
    sb.push_back(y);
`ifdef RQ_ARB_PRIO0_EN
    sb.push_back(w);
    sb.push_back(z);
`else
    sb.push_back(z);
    sb.push_back(w);
`endif
    run();
    checks++;
`ifdef RQ_ARB_PRIO0_EN
    if (grant_owner !== 2'd2) begin
      errors++;
      $display("FAIL prio_owner: got %0d required 2", grant_owner);
    end
`else
    if (grant_owner !== 2'd0) begin
      errors++;
      $display("FAIL prio_owner: got %0d required 0", grant_owner);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_round_robin();
    test_atomicity();
    test_backpressure();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
